// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared fetch-stage types and instruction field layout
package if_pkg;
    typedef enum logic [1:0] {S_START, S_FETCH, S_DRAIN} fetch_state_t;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam int FIELD_W   = 4;
    localparam int OPC_LSB   = 12;
    localparam int ONE_LSB   = 8;
    localparam int TWO_LSB   = 4;
    localparam int THREE_LSB = 0;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory request/response bus
interface if_fetch_unit_if #(parameter int PC_W = 16);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [15:0]     rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit_fetch_slot_queue.sv
// fetch_slot_queue: ring of fetch slots allocated at issue, filled in order by responses, popped at head
module fetch_slot_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_alloc,
    input  logic [PC_W-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [15:0]     i_fill_data,
    input  logic            i_pop,
    output logic            o_full,
    output logic            o_head_filled,
    output logic [PC_W-1:0] o_head_pc,
    output logic [15:0]     o_head_data,
    output logic [AW:0]     o_unfilled
);
    logic [PC_W-1:0]  r_pc [DEPTH];
    logic [15:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [AW:0]      r_head, r_fill, r_tail;
    logic [AW:0]      w_count;
    logic             w_fill_ok;

    assign w_count       = r_tail - r_head;
    assign o_full        = w_count == (AW+1)'(DEPTH);
    assign o_unfilled    = r_tail - r_fill;
    assign w_fill_ok     = i_fill && (r_fill != r_tail);
    assign o_head_filled = (r_head != r_tail) && r_filled[r_head[AW-1:0]];
    assign o_head_pc     = r_pc[r_head[AW-1:0]];
    assign o_head_data   = r_data[r_head[AW-1:0]];

    // pointer/slot update; a response with no unfilled slot is dropped silently
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head   <= '0;
            r_fill   <= '0;
            r_tail   <= '0;
            r_filled <= '0;
        end else begin
            if (i_alloc) begin
                r_pc[r_tail[AW-1:0]]     <= i_alloc_pc;
                r_filled[r_tail[AW-1:0]] <= 1'b0;
                r_tail                   <= r_tail + 1'b1;
            end
            if (w_fill_ok) begin
                r_data[r_fill[AW-1:0]]   <= i_fill_data;
                r_filled[r_fill[AW-1:0]] <= 1'b1;
                r_fill                   <= r_fill + 1'b1;
            end
            if (i_pop)
                r_head <= r_head + 1'b1;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch FSM feeding IF/ID; optional IFETCH_STATS_EN adds stall/bubble counters
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              DEPTH    = 2,
    parameter int              PC_INC   = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazard,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    if_fetch_unit_if.master   imem,
    output logic [PC_W-1:0]   pc_o,
    output logic [3:0]        opcode_o,
    output logic [3:0]        one_o,
    output logic [3:0]        two_o,
    output logic [3:0]        three_o
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       bubble_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH + 1);

    fetch_state_t    r_state, w_state_next;
    logic [PC_W-1:0] r_fetch_pc;
    logic [DW-1:0]   r_drop, w_drop_next;
    logic            w_full, w_head_filled, w_issue, w_fill, w_pop, w_show;
    logic [PC_W-1:0] w_head_pc;
    logic [15:0]     w_head_data, w_word;
    logic [AW:0]     w_unfilled;

    // requests stop in the redirect cycle so a granted request is always allocated
    assign imem.req  = (r_state == S_FETCH) && !w_full && !redirect;
    assign imem.addr = r_fetch_pc;
    assign w_issue   = imem.req && imem.gnt;
    assign w_fill    = imem.rvalid && (r_drop == '0);
    assign w_show    = w_head_filled && !redirect;
    assign w_pop     = w_show && !hazard;

    fetch_slot_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) u_queue (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (redirect),
        .i_alloc       (w_issue),
        .i_alloc_pc    (r_fetch_pc),
        .i_fill        (w_fill),
        .i_fill_data   (imem.rdata),
        .i_pop         (w_pop),
        .o_full        (w_full),
        .o_head_filled (w_head_filled),
        .o_head_pc     (w_head_pc),
        .o_head_data   (w_head_data),
        .o_unfilled    (w_unfilled)
    );

    // next state and count of stale responses still to be discarded
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        if (redirect) begin
            w_drop_next  = (r_drop != '0) ? r_drop - DW'(imem.rvalid)
                                          : DW'(w_unfilled) - DW'(imem.rvalid && w_unfilled != '0);
            w_state_next = (w_drop_next != '0) ? S_DRAIN : S_FETCH;
        end else if (r_state == S_START) begin
            w_state_next = S_FETCH;
        end else if (r_state == S_DRAIN) begin
            w_drop_next  = r_drop - DW'(imem.rvalid);
            w_state_next = (w_drop_next == '0) ? S_FETCH : S_DRAIN;
        end
    end

    // state, drop counter and fetch PC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_START;
            r_drop     <= '0;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_drop     <= w_drop_next;
            r_fetch_pc <= redirect ? redirect_pc : w_issue ? r_fetch_pc + PC_W'(PC_INC) : r_fetch_pc;
        end
    end

    assign w_word   = w_show ? w_head_data : NOP_INSTR;
    assign pc_o     = w_show ? w_head_pc : '0;
    assign opcode_o = w_word[OPC_LSB +: FIELD_W];
    assign one_o    = w_word[ONE_LSB +: FIELD_W];
    assign two_o    = w_word[TWO_LSB +: FIELD_W];
    assign three_o  = w_word[THREE_LSB +: FIELD_W];

`ifdef IFETCH_STATS_EN
    // saturating counts of stalled-valid cycles and bubble cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (hazard && w_head_filled && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
            if (!w_show && bubble_cnt_o != 16'hFFFF)
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: queue-level reference model plus directed fetch/hazard/redirect/wrap scenarios
module tb_if_fetch_unit;
    typedef struct {logic [15:0] pc; logic [15:0] data;} ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, hazard = 1'b0, redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        gnt_en = 1'b0, rv_en = 1'b0;
    logic [15:0] pc_o, pc2;
    logic [3:0]  opcode_o, one_o, two_o, three_o, op2, one2, two2, three2;
    logic        iss2 = 1'b0;
    logic [15:0] a2 = 16'h0;
`ifdef IFETCH_STATS_EN
    logic [15:0] stall_cnt, bubble_cnt, stall2, bubble2;
    logic [15:0] m_stall, m_bubble;
`endif
    int n_cmp = 0, n_bad = 0;

    logic [15:0] mq[$];
    ent_t        m_ready[$];
    logic [15:0] m_pend[$];
    int          m_drop;
    bit          m_started;
    logic [15:0] m_pc;
    bit          e_req, show;
    ent_t        h, tmp;

    always #5 clk = ~clk;

    if_fetch_unit_if #(.PC_W(16)) mif();
    if_fetch_unit_if #(.PC_W(16)) mif2();

    if_fetch_unit #(.PC_W(16), .DEPTH(2), .PC_INC(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .hazard(hazard), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(mif), .pc_o(pc_o), .opcode_o(opcode_o), .one_o(one_o), .two_o(two_o), .three_o(three_o)
`ifdef IFETCH_STATS_EN
        , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
    );

    if_fetch_unit #(.PC_W(16), .DEPTH(2), .PC_INC(2), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset), .hazard(1'b0), .redirect(1'b0), .redirect_pc(16'h0),
        .imem(mif2), .pc_o(pc2), .opcode_o(op2), .one_o(one2), .two_o(two2), .three_o(three2)
`ifdef IFETCH_STATS_EN
        , .stall_cnt_o(stall2), .bubble_cnt_o(bubble2)
`endif
    );

    function automatic logic [15:0] word(input logic [15:0] a);
        return a == 16'h0000 ? 16'h1234 : a == 16'h0002 ? 16'h5678 : a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; hazard = 1'b0; redirect = 1'b0; gnt_en = 1'b0; rv_en = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    assign mif.gnt  = gnt_en;
    assign mif2.gnt = 1'b1;

    // memory for the main DUT: one-cycle-minimum latency, in order, throttled by rv_en
    always @(posedge clk) begin
        #2;
        mif.rvalid = rv_en && !reset && mq.size() > 0;
        mif.rdata  = mq.size() > 0 ? word(mq[0]) : 16'h0;
    end

    // memory for the wrap instance: every grant answered next cycle with the address as data
    always @(negedge clk) begin
        iss2 = mif2.req && !reset;
        a2   = mif2.addr;
    end
    always @(posedge clk) begin
        #2;
        mif2.rvalid = iss2 && !reset;
        mif2.rdata  = a2;
    end

    // per-cycle compare against the queue model, then advance model and memory
    always @(negedge clk) begin
        if (reset) begin
            m_ready.delete(); m_pend.delete(); mq.delete();
            m_drop = 0; m_started = 0; m_pc = 16'h0000;
`ifdef IFETCH_STATS_EN
            m_stall = 16'h0; m_bubble = 16'h0;
`endif
        end else begin
            show  = m_ready.size() > 0 && !redirect;
            e_req = m_started && m_drop == 0 && (m_ready.size() + m_pend.size()) < 2 && !redirect;
            h     = show ? m_ready[0] : '{16'h0, 16'h0};
            chk("req", 16'(mif.req), 16'(e_req));
            if (e_req) chk("addr", mif.addr, m_pc);
            chk("pc_o", pc_o, h.pc);
            chk("opcode", 16'(opcode_o), 16'(h.data[15:12]));
            chk("one", 16'(one_o), 16'(h.data[11:8]));
            chk("two", 16'(two_o), 16'(h.data[7:4]));
            chk("three", 16'(three_o), 16'(h.data[3:0]));
`ifdef IFETCH_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("bubble_cnt", bubble_cnt, m_bubble);
            if (hazard && m_ready.size() > 0 && m_stall != 16'hFFFF) m_stall++;
            if (!show && m_bubble != 16'hFFFF) m_bubble++;
`endif
            if (mif.rvalid && mq.size() > 0) void'(mq.pop_front());
            if (mif.req && mif.gnt) mq.push_back(mif.addr);
            if (show && !hazard) void'(m_ready.pop_front());
            if (redirect) begin
                m_drop = m_drop > 0 ? m_drop - int'(mif.rvalid)
                                    : m_pend.size() - int'(mif.rvalid && m_pend.size() > 0);
                m_ready.delete(); m_pend.delete();
                m_pc = redirect_pc;
            end else begin
                if (mif.rvalid) begin
                    if (m_drop > 0) m_drop--;
                    else if (m_pend.size() > 0) begin
                        tmp.pc   = m_pend.pop_front();
                        tmp.data = mif.rdata;
                        m_ready.push_back(tmp);
                    end
                end
                if (e_req && mif.gnt) begin
                    m_pend.push_back(m_pc);
                    m_pc = m_pc + 16'd2;
                end
            end
            m_started = 1;
        end
    end

    initial begin
        bit found;
        // free-running fetch, plus the reset-at-FFFE wrap instance alongside
        do_reset();
        gnt_en = 1'b1; rv_en = 1'b1;
        @(negedge clk);
        chk("t1 c0 req", 16'(mif.req), 16'h0);
        chk("t1 c0 opcode", 16'(opcode_o), 16'h0);
        chk("t5 c0 req", 16'(mif2.req), 16'h0);
        step(); @(negedge clk);
        chk("t1 c1 req", 16'(mif.req), 16'h1);
        chk("t1 c1 addr", mif.addr, 16'h0000);
        chk("t5 c1 addr", mif2.addr, 16'hFFFE);
        step(); @(negedge clk);
        chk("t1 c2 addr", mif.addr, 16'h0002);
        chk("t5 c2 addr", mif2.addr, 16'h0000);
        step(); @(negedge clk);
        chk("t1 c3 pc", pc_o, 16'h0000);
        chk("t1 c3 fields", {opcode_o, one_o, two_o, three_o}, 16'h1234);
        chk("t5 c3 pc", pc2, 16'hFFFE);
        step(); @(negedge clk);
        chk("t1 c4 pc", pc_o, 16'h0002);
        chk("t1 c4 fields", {opcode_o, one_o, two_o, three_o}, 16'h5678);
        chk("t5 c4 pc", pc2, 16'h0000);

        // hazard held for three cycles on a filled head
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_ready.size() > 0) begin found = 1; break; end
        end
        chk("t2 head filled in time", 16'(found), 16'h1);
        hazard = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2 hold req", 16'(mif.req), 16'h0);
        chk("t2 hold pc", pc_o, 16'h0004);
        chk("t2 hold opcode", 16'(opcode_o), 16'hC);
        step(); hazard = 1'b0;
        @(negedge clk);
        chk("t2 release pc", pc_o, 16'h0004);
        step(); @(negedge clk);
        chk("t2 next pc", pc_o, 16'h0006);
        chk("t2 next addr", mif.addr, 16'h0008);

        // redirect with two requests outstanding
        do_reset();
        gnt_en = 1'b1;
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        chk("t3 redirect opcode", 16'(opcode_o), 16'h0);
        step(); redirect = 1'b0; rv_en = 1'b1;
        @(negedge clk);
        chk("t3 drain1 req", 16'(mif.req), 16'h0);
        chk("t3 drain1 pc", pc_o, 16'h0000);
        step(); @(negedge clk);
        chk("t3 drain2 req", 16'(mif.req), 16'h0);
        step(); @(negedge clk);
        chk("t3 resume req", 16'(mif.req), 16'h1);
        chk("t3 resume addr", mif.addr, 16'h0100);
        step(); step(); @(negedge clk);
        chk("t3 new pc", pc_o, 16'h0100);
        chk("t3 new opcode", 16'(opcode_o), 16'hC);

        // redirect coinciding with the only outstanding response
        do_reset();
        rv_en = 1'b1;
        step(); gnt_en = 1'b1;
        @(negedge clk);
        chk("t4 issue addr", mif.addr, 16'h0000);
        step(); gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0200;
        @(negedge clk);
        chk("t4 redirect pc", pc_o, 16'h0000);
        step(); redirect = 1'b0; gnt_en = 1'b1;
        @(negedge clk);
        chk("t4 direct req", 16'(mif.req), 16'h1);
        chk("t4 direct addr", mif.addr, 16'h0200);
        chk("t4 bubble opcode", 16'(opcode_o), 16'h0);
        step(); step(); @(negedge clk);
        chk("t4 new pc", pc_o, 16'h0200);

        // mixed pattern of grants, response gaps, hazards and redirects
        for (int i = 0; i < 150; i++) begin
            step();
            gnt_en      = (i % 3) != 0;
            rv_en       = (i % 4) != 1;
            hazard      = (i % 5) == 2;
            redirect    = (i % 17) == 9 || (i % 17) == 11;
            redirect_pc = 16'(i * 4);
        end
        step();
        redirect = 1'b0; hazard = 1'b0;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
